// File: rtl/uart_pkg.sv
// Shared types and constants for the UART engine: FSM state encodings,
// oversample ratio, frame data width and the baud divider calculation.
package uart_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;

  // Sysclk cycles per oversample tick, rounded to nearest and never below 1.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    int unsigned d;
    d = (clk_freq + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator: counts 0..DIV-1 and strobes
// tick16 for one sysclk on the cycle the count wraps.
module uart_baud_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic sysclk,
  input  logic reset,
  output logic tick16
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick16 = (cnt_q == CNT_TOP);
    cnt_d  = tick16 ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_core.sv
// 8N1 UART engine: baud generator, oversampling receiver and transmitter.
// Define UART_LOOPBACK_EN to feed the receiver from UART_txd instead of UART_rxd.
//
// rx state | meaning
// RX_IDLE  | waiting for a low rxs on a tick16 while rx_en is high
// RX_START | counting to mid start bit, rejects glitches
// RX_DATA  | sampling 8 data bits at mid-bit, LSB first
// RX_STOP  | sampling stop bit; commits byte only if it is high
//
// tx state | meaning
// TX_IDLE  | line high, tx_status high, waiting for an accepted request
// TX_SHIFT | driving start, d0..d7, stop; each bit 16*DIV sysclk
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned DIV      = calc_div(CLK_FREQ, BAUD)
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       UART_rxd,
  input  logic       rx_en,
  output logic [7:0] rx_data,
  output logic       rx_status,
  input  logic       tx_en,
  input  logic [7:0] txdata,
  input  logic       txstop,
  output logic       tx_status,
  output logic       UART_txd
);

  localparam int unsigned BIT_CYC = OVERSAMPLE * DIV;
  localparam int unsigned TW      = $clog2(BIT_CYC);
  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_CYC - 1);
  localparam logic [3:0]    MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_BIT  = 4'(DATA_BITS + 1);

  logic tick16;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .sysclk (sysclk),
    .reset  (reset),
    .tick16 (tick16)
  );

  logic txd_q, txd_d;
  logic rx_src;

`ifdef UART_LOOPBACK_EN
  assign rx_src = txd_q;
`else
  assign rx_src = UART_rxd;
`endif

  logic sync1_q, sync2_q, rxs;
  assign rxs = sync2_q;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_src;
      sync2_q <= sync1_q;
    end
  end

  rx_state_t  rx_state_q, rx_state_d;
  logic [3:0] rx_tick_q, rx_tick_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_status_q, rx_status_d;

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_tick_d   = rx_tick_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_status_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (tick16 && rx_en && !rxs) begin
          rx_state_d = RX_START;
          rx_tick_d  = '0;
        end
      end
      RX_START: begin
        if (tick16) begin
          if (rx_tick_q == MID_TICK) begin
            rx_tick_d  = '0;
            rx_bit_d   = '0;
            rx_state_d = rxs ? RX_IDLE : RX_DATA;
          end else begin
            rx_tick_d = rx_tick_q + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick16) begin
          if (rx_tick_q == LAST_TICK) begin
            rx_tick_d  = '0;
            rx_shift_d = {rxs, rx_shift_q[7:1]};
            if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
            else                      rx_bit_d   = rx_bit_q + 3'd1;
          end else begin
            rx_tick_d = rx_tick_q + 4'd1;
          end
        end
      end
      RX_STOP: begin
        if (tick16) begin
          if (rx_tick_q == LAST_TICK) begin
            rx_tick_d  = '0;
            rx_state_d = RX_IDLE;
            // A low stop bit is a framing error: drop the byte silently.
            if (rxs) begin
              rx_data_d   = rx_shift_q;
              rx_status_d = 1'b1;
            end
          end else begin
            rx_tick_d = rx_tick_q + 4'd1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_state_q  <= RX_IDLE;
      rx_tick_q   <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_status_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_tick_q   <= rx_tick_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_status_q <= rx_status_d;
    end
  end

  tx_state_t     tx_state_q, tx_state_d;
  logic [TW-1:0] tx_timer_q, tx_timer_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [8:0]    tx_frame_q, tx_frame_d;
  logic          tx_status_q, tx_status_d;

  // The bit timer is a down-counter reloaded at acceptance, so frame timing
  // is independent of the free-running tick16 phase.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_timer_d  = tx_timer_q;
    tx_bit_d    = tx_bit_q;
    tx_frame_d  = tx_frame_q;
    tx_status_d = tx_status_q;
    txd_d       = txd_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_en && !txstop && tx_status_q) begin
          tx_state_d  = TX_SHIFT;
          tx_frame_d  = {1'b1, txdata};
          tx_timer_d  = BIT_LAST;
          tx_bit_d    = '0;
          tx_status_d = 1'b0;
          txd_d       = 1'b0;
        end
      end
      TX_SHIFT: begin
        if (tx_timer_q == '0) begin
          if (tx_bit_q == STOP_BIT) begin
            tx_state_d  = TX_IDLE;
            tx_status_d = 1'b1;
            txd_d       = 1'b1;
          end else begin
            txd_d      = tx_frame_q[0];
            tx_frame_d = {1'b1, tx_frame_q[8:1]};
            tx_bit_d   = tx_bit_q + 4'd1;
            tx_timer_d = BIT_LAST;
          end
        end else begin
          tx_timer_d = tx_timer_q - TW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      tx_state_q  <= TX_IDLE;
      tx_timer_q  <= '0;
      tx_bit_q    <= '0;
      tx_frame_q  <= '0;
      tx_status_q <= 1'b1;
      txd_q       <= 1'b1;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_timer_q  <= tx_timer_d;
      tx_bit_q    <= tx_bit_d;
      tx_frame_q  <= tx_frame_d;
      tx_status_q <= tx_status_d;
      txd_q       <= txd_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_status = rx_status_q;
  assign tx_status = tx_status_q;
  assign UART_txd  = txd_q;

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core at 1.6 MHz / 10 kbaud (DIV=10, 160 sysclk per bit).
// Transmit side checked every cycle against a timing model; receive side per frame.
module tb_uart_core;

  logic       sysclk   = 1'b0;
  logic       reset    = 1'b0;
  logic       UART_rxd = 1'b1;
  logic       rx_en    = 1'b0;
  logic       tx_en    = 1'b0;
  logic [7:0] txdata   = 8'h00;
  logic       txstop   = 1'b0;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       tx_status;
  logic       UART_txd;

  localparam int BIT_T = 160;

  always #5 sysclk = ~sysclk;

  uart_core #(.CLK_FREQ(1_600_000), .BAUD(10_000)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .UART_rxd  (UART_rxd),
    .rx_en     (rx_en),
    .rx_data   (rx_data),
    .rx_status (rx_status),
    .tx_en     (tx_en),
    .txdata    (txdata),
    .txstop    (txstop),
    .tx_status (tx_status),
    .UART_txd  (UART_txd)
  );

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  bit         m_busy = 1'b0;
  int         m_start = 0;
  int         m_e, m_idx;
  logic [7:0] m_byte = 8'h00;
  logic       m_txd = 1'b1;
  logic       m_txs = 1'b1;
  logic [7:0] m_rx_data = 8'h00;
  bit         rx_quiet = 1'b1;
  bit         chk_en = 1'b0;
  int         pulse_cnt = 0;
  int         last_pulse = 0;
  logic       prev_rxs = 1'b0;

  // Transmit model: a frame is 10 bits of BIT_T cycles measured from acceptance.
  always @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      m_busy = 1'b0;
    end else begin
      cyc = cyc + 1;
      if (m_busy && (cyc - m_start) == 10 * BIT_T) begin
        m_busy = 1'b0;
      end else if (!m_busy && tx_en && !txstop) begin
        m_busy  = 1'b1;
        m_start = cyc;
        m_byte  = txdata;
      end
    end
    if (m_busy) begin
      m_e   = cyc - m_start;
      m_idx = m_e / BIT_T;
      if (m_idx == 0)      m_txd = 1'b0;
      else if (m_idx >= 9) m_txd = 1'b1;
      else                 m_txd = m_byte[m_idx-1];
      m_txs = 1'b0;
    end else begin
      m_txd = 1'b1;
      m_txs = 1'b1;
    end
  end

  always @(negedge sysclk) begin
    if (chk_en) begin
      total++;
      if (UART_txd !== m_txd) begin
        bad++;
        $display("FAIL txd cyc=%0d got=%b exp=%b", cyc, UART_txd, m_txd);
      end
      total++;
      if (tx_status !== m_txs) begin
        bad++;
        $display("FAIL tx_status cyc=%0d got=%b exp=%b", cyc, tx_status, m_txs);
      end
      if (rx_quiet) begin
        total++;
        if (rx_data !== m_rx_data) begin
          bad++;
          $display("FAIL rx_data_hold cyc=%0d got=%h exp=%h", cyc, rx_data, m_rx_data);
        end
      end
      if (rx_status === 1'b1) begin
        pulse_cnt++;
        last_pulse = cyc;
        total++;
        if (prev_rxs === 1'b1) begin
          bad++;
          $display("FAIL rx_status_width cyc=%0d got=2+cycles exp=1", cyc);
        end
      end
      prev_rxs = rx_status;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tx_pulse(input logic [7:0] b);
    @(negedge sysclk);
    txdata = b;
    tx_en  = 1'b1;
    @(negedge sysclk);
    tx_en  = 1'b0;
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_b);
    logic [9:0] fr;
    fr = {stop_b, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      UART_rxd = fr[k];
      repeat (BIT_T) @(negedge sysclk);
    end
    UART_rxd = 1'b1;
  endtask

  // Drives one frame and checks pulse count, pulse timing and the held byte.
  task automatic rx_case(input string name, input logic [7:0] b, input logic stop_b,
                         input bit en, input bit expect_pulse);
    int p0, t0, d;
    @(negedge sysclk);
    rx_en = en;
    if (expect_pulse) rx_quiet = 1'b0;
    p0 = pulse_cnt;
    t0 = cyc;
    drive_frame(b, stop_b);
    repeat (300) @(negedge sysclk);
    check({name, "_pulses"}, pulse_cnt - p0, expect_pulse ? 1 : 0);
    if (expect_pulse) begin
      d = last_pulse - t0;
      total++;
      if (d < 1515 || d > 1545) begin
        bad++;
        $display("FAIL %s_latency got=%0d exp=1515..1545", name, d);
      end
      m_rx_data = b;
    end
    check({name, "_data"}, rx_data, m_rx_data);
    rx_quiet = 1'b1;
    rx_en = 1'b0;
  endtask

  initial begin
    logic [9:0] a5_wave;
    int p0;
    a5_wave = 10'b11_0100_1010;

    repeat (3) @(negedge sysclk);
    check("reset_txd", UART_txd, 1);
    check("reset_tx_status", tx_status, 1);
    check("reset_rx_status", rx_status, 0);
    check("reset_rx_data", rx_data, 8'h00);
    reset = 1'b1;
    chk_en = 1'b1;
    repeat (20) @(negedge sysclk);

    tx_pulse(8'hA5);
    repeat (BIT_T / 2) @(negedge sysclk);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("a5_bit%0d", k), UART_txd, a5_wave[k]);
      if (k < 9) repeat (BIT_T) @(negedge sysclk);
    end
    repeat (79) @(negedge sysclk);
    check("a5_busy_last", tx_status, 0);
    @(negedge sysclk);
    check("a5_ready_at_1600", tx_status, 1);
    repeat (20) @(negedge sysclk);

    @(negedge sysclk);
    txstop = 1'b1;
    txdata = 8'hFF;
    tx_en  = 1'b1;
    repeat (300) @(negedge sysclk);
    check("txstop_txd", UART_txd, 1);
    check("txstop_status", tx_status, 1);
    tx_en  = 1'b0;
    txstop = 1'b0;
    repeat (5) @(negedge sysclk);

    tx_pulse(8'h0F);
    repeat (500) @(negedge sysclk);
    txdata = 8'hF0;
    tx_en  = 1'b1;
    repeat (3) @(negedge sysclk);
    tx_en  = 1'b0;
    repeat (1200) @(negedge sysclk);
    check("busy_ignored_ready", tx_status, 1);

    @(negedge sysclk);
    txdata = 8'h81;
    tx_en  = 1'b1;
    repeat (1700) @(negedge sysclk);
    check("level_rearm_busy", tx_status, 0);
    tx_en  = 1'b0;
    repeat (1600) @(negedge sysclk);

`ifndef UART_LOOPBACK_EN
    rx_case("rx_3c", 8'h3C, 1'b1, 1'b1, 1'b1);
    rx_case("rx_disabled", 8'h3C, 1'b1, 1'b0, 1'b0);

    @(negedge sysclk);
    rx_en = 1'b1;
    p0 = pulse_cnt;
    UART_rxd = 1'b0;
    repeat (40) @(negedge sysclk);
    UART_rxd = 1'b1;
    repeat (400) @(negedge sysclk);
    check("glitch_pulses", pulse_cnt - p0, 0);
    rx_en = 1'b0;

    rx_case("rx_frame_err", 8'h55, 1'b0, 1'b1, 1'b0);

    @(negedge sysclk);
    rx_en = 1'b1;
    rx_quiet = 1'b0;
    p0 = pulse_cnt;
    drive_frame(8'h12, 1'b1);
    drive_frame(8'h34, 1'b1);
    repeat (300) @(negedge sysclk);
    check("b2b_pulses", pulse_cnt - p0, 2);
    check("b2b_data", rx_data, 8'h34);
    m_rx_data = 8'h34;
    rx_quiet = 1'b1;
    rx_en = 1'b0;
`else
    @(negedge sysclk);
    rx_en = 1'b1;
    rx_quiet = 1'b0;
    p0 = pulse_cnt;
    tx_pulse(8'hC3);
    repeat (1800) @(negedge sysclk);
    check("loop_pulses", pulse_cnt - p0, 1);
    check("loop_data", rx_data, 8'hC3);
    m_rx_data = 8'hC3;
    rx_quiet = 1'b1;
    rx_en = 1'b0;
`endif

    tx_pulse(8'h00);
    repeat (300) @(negedge sysclk);
    check("pre_reset_txd", UART_txd, 0);
    @(posedge sysclk);
    #2;
    m_rx_data = 8'h00;
    reset = 1'b0;
    #1;
    check("midreset_txd", UART_txd, 1);
    check("midreset_status", tx_status, 1);
    repeat (3) @(negedge sysclk);
    reset = 1'b1;
    repeat (20) @(negedge sysclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
